// File: rtl/fp_operand_sequencer.sv
// -----------------------------------------------------------------------------
// fp_operand_sequencer
//
// Upstream feeder for a serial single-precision FP adder. Operand pairs are
// queued in a small FIFO, then each pair is driven onto the adder's single
// 32-bit operand bus on two consecutive cycles (A, then B). The sequencer waits
// for the adder's ready rising edge, captures the sum and holds it on a
// valid/ready result port until consumed.
//
// Parameters:
//   DEPTH      operand-pair FIFO entries (power of 2, >= 2)
//
// Ports:
//   clock      system clock, rising edge
//   nreset     asynchronous active-low reset (shared with the adder)
//   in_valid   operand pair offered
//   in_ready   FIFO not full (low while nreset is asserted)
//   in_a       first operand (IEEE-754 single bits)
//   in_b       second operand
//   add_a      operand bus to the adder
//   add_ready  adder ready; its rising edge marks init done / sum valid
//   add_sum    adder sum, valid on the add_ready rising edge
//   res_valid  result held
//   res_ready  result consumed when res_valid && res_ready
//   res_data   captured sum
//
// Build option:
//   FPSEQ_ZERO_BYPASS_EN  when defined, a head pair containing a +/-0 operand
//                         is resolved locally without driving the adder.
// -----------------------------------------------------------------------------
module fp_operand_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        nreset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] add_a,
    input  logic        add_ready,
    input  logic [31:0] add_sum,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] ST_BOOT = 3'd0;
    localparam logic [2:0] ST_IDLE = 3'd1;
    localparam logic [2:0] ST_OPA  = 3'd2;
    localparam logic [2:0] ST_OPB  = 3'd3;
    localparam logic [2:0] ST_WAIT = 3'd4;

    logic [2:0]    state_q, state_d;
    logic          rdy_q;
    logic          rise;

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   mem_a_q [DEPTH];
    logic [31:0]   mem_b_q [DEPTH];
    logic          full, empty, push, pop;
    logic [31:0]   head_a, head_b;

    logic [31:0]   opb_q, opb_d;
    logic [31:0]   add_a_q, add_a_d;
    logic          res_valid_q, res_valid_d;
    logic [31:0]   res_data_q, res_data_d;

`ifdef FPSEQ_ZERO_BYPASS_EN
    // +/-0 only: exponent and mantissa all zero; denormals go to the adder.
    function automatic logic is_zero(input logic [31:0] v);
        return (v[30:0] == 31'd0);
    endfunction
`endif

    assign rise   = add_ready & ~rdy_q;
    assign full   = (count_q == (AW+1)'(DEPTH));
    assign empty  = (count_q == '0);
    // Gated by nreset so upstream sees "not ready" for the whole reset pulse.
    assign in_ready = nreset & ~full;
    assign push   = in_valid & in_ready;
    assign head_a = mem_a_q[rd_ptr_q];
    assign head_b = mem_b_q[rd_ptr_q];

    assign add_a     = add_a_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

    always_comb begin
        state_d     = state_q;
        add_a_d     = add_a_q;
        opb_d       = opb_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        pop         = 1'b0;

        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end

        case (state_q)
            ST_BOOT: begin
                if (rise) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                // A held, unconsumed result blocks the next pop so it is never overwritten.
                if (!empty && !res_valid_q) begin
                    pop = 1'b1;
`ifdef FPSEQ_ZERO_BYPASS_EN
                    if (is_zero(head_a) || is_zero(head_b)) begin
                        res_valid_d = 1'b1;
                        if (is_zero(head_a) && is_zero(head_b)) begin
                            res_data_d = {head_a[31] & head_b[31], 31'd0};
                        end else if (is_zero(head_a)) begin
                            res_data_d = head_b;
                        end else begin
                            res_data_d = head_a;
                        end
                    end else begin
                        add_a_d = head_a;
                        opb_d   = head_b;
                        state_d = ST_OPA;
                    end
`else
                    add_a_d = head_a;
                    opb_d   = head_b;
                    state_d = ST_OPA;
`endif
                end
            end
            ST_OPA: begin
                // B is kept locally because the FIFO slot is already released.
                add_a_d = opb_q;
                state_d = ST_OPB;
            end
            ST_OPB: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (rise) begin
                    res_data_d  = add_sum;
                    res_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q     <= ST_BOOT;
            rdy_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            opb_q       <= '0;
            add_a_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= add_ready;
            count_q     <= count_d;
            opb_q       <= opb_d;
            add_a_q     <= add_a_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            // Power-of-2 depth: pointers wrap naturally at AW bits.
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // Storage needs no reset: entries are only read while the count says valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_a_q[wr_ptr_q] <= in_a;
            mem_b_q[wr_ptr_q] <= in_b;
        end
    end

endmodule

// File: tb/tb_fp_operand_sequencer.sv
module tb_fp_operand_sequencer;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        nreset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] add_a;
    logic        add_ready;
    logic [31:0] add_sum;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    fp_operand_sequencer #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .nreset    (nreset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_a     (add_a),
        .add_ready (add_ready),
        .add_sum   (add_sum),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset;
        nreset    = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        add_ready = 1'b0;
        add_sum   = '0;
        res_ready = 1'b0;
        repeat (3) tick();
        nreset = 1'b1;
        #1;
    endtask

    task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
    endtask

    // One ready pulse: BOOT -> IDLE; the following edge is the first pop edge.
    task automatic boot_adder;
        add_ready = 1'b1;
        tick();
        add_ready = 1'b0;
    endtask

    // Plays the adder for one pair, starting one edge before the expected pop.
    task automatic run_pair(input string name, input logic [31:0] ea, input logic [31:0] eb,
                            input logic [31:0] sum, input bit consume);
        tick();
        n_checks++; if (add_a !== ea) $display("FAIL %s opA: add_a=%h expected %h", name, add_a, ea); else n_pass++;
        tick();
        n_checks++; if (add_a !== eb) $display("FAIL %s opB: add_a=%h expected %h", name, add_a, eb); else n_pass++;
        tick();
        n_checks++; if (add_a !== eb || res_valid !== 1'b0)
            $display("FAIL %s wait: add_a=%h res_valid=%b expected %h/0", name, add_a, res_valid, eb); else n_pass++;
        add_sum   = sum;
        add_ready = 1'b1;
        tick();
        add_ready = 1'b0;
        n_checks++; if (res_valid !== 1'b1) $display("FAIL %s res_valid: got %b expected 1", name, res_valid); else n_pass++;
        n_checks++; if (res_data !== sum) $display("FAIL %s res_data: got %h expected %h", name, res_data, sum); else n_pass++;
        if (consume) begin
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            n_checks++; if (res_valid !== 1'b0) $display("FAIL %s consume: res_valid=%b expected 0", name, res_valid); else n_pass++;
        end
    endtask

    task automatic test_reset;
        nreset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        add_ready = 1'b0; add_sum = '0; res_ready = 1'b0;
        tick();
        n_checks++; if (in_ready !== 1'b0) $display("FAIL reset in_ready: got %b expected 0", in_ready); else n_pass++;
        n_checks++; if (add_a !== 32'h0) $display("FAIL reset add_a: got %h expected 0", add_a); else n_pass++;
        n_checks++; if (res_valid !== 1'b0) $display("FAIL reset res_valid: got %b expected 0", res_valid); else n_pass++;
        n_checks++; if (res_data !== 32'h0) $display("FAIL reset res_data: got %h expected 0", res_data); else n_pass++;
        nreset = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL release in_ready: got %b expected 1", in_ready); else n_pass++;
    endtask

    task automatic test_boot_hold;
        push_pair(32'h3F800000, 32'h3F800000);
        repeat (10) tick();
        n_checks++; if (add_a !== 32'h0) $display("FAIL boot add_a: got %h expected 0", add_a); else n_pass++;
        n_checks++; if (res_valid !== 1'b0) $display("FAIL boot res_valid: got %b expected 0", res_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL boot in_ready: got %b expected 1", in_ready); else n_pass++;
    endtask

    task automatic test_basic;
        boot_adder();
        run_pair("basic", 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b1);
    endtask

    task automatic test_fifo_full;
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++; if (in_ready !== 1'b1) $display("FAIL fill in_ready[%0d]: got %b expected 1", i, in_ready); else n_pass++;
            push_pair(32'h40000000 | i, 32'h41000000 | i);
        end
        n_checks++; if (in_ready !== 1'b0) $display("FAIL full in_ready: got %b expected 0", in_ready); else n_pass++;
        push_pair(32'h4F00000F, 32'h4F0000F0);
        boot_adder();
        for (int i = 0; i < DEPTH; i++) begin
            run_pair($sformatf("order%0d", i), 32'h40000000 | i, 32'h41000000 | i, 32'h42000000 | i, 1'b1);
        end
        repeat (4) tick();
        n_checks++; if (add_a !== (32'h41000000 | (DEPTH - 1)))
            $display("FAIL dropped push: add_a=%h expected %h", add_a, 32'h41000000 | (DEPTH - 1)); else n_pass++;
        n_checks++; if (res_valid !== 1'b0) $display("FAIL dropped res_valid: got %b expected 0", res_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL drained in_ready: got %b expected 1", in_ready); else n_pass++;
    endtask

    task automatic test_res_stall;
        apply_reset();
        push_pair(32'h3FC00000, 32'h40200000);
        push_pair(32'h40800000, 32'hBF800000);
        boot_adder();
        run_pair("stall1", 32'h3FC00000, 32'h40200000, 32'h40800000, 1'b0);
        repeat (6) tick();
        n_checks++; if (add_a !== 32'h40200000) $display("FAIL stall add_a: got %h expected 40200000", add_a); else n_pass++;
        n_checks++; if (res_valid !== 1'b1 || res_data !== 32'h40800000)
            $display("FAIL stall hold: res_valid=%b res_data=%h expected 1/40800000", res_valid, res_data); else n_pass++;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_checks++; if (res_valid !== 1'b0) $display("FAIL stall consume: res_valid=%b expected 0", res_valid); else n_pass++;
        run_pair("stall2", 32'h40800000, 32'hBF800000, 32'h40400000, 1'b1);
    endtask

    task automatic test_reset_mid;
        apply_reset();
        push_pair(32'h3F000000, 32'h3E800000);
        push_pair(32'h3E000000, 32'h3D800000);
        boot_adder();
        repeat (3) tick();
        nreset = 1'b0;
        #1;
        n_checks++; if (res_valid !== 1'b0) $display("FAIL midrst res_valid: got %b expected 0", res_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL midrst in_ready: got %b expected 0", in_ready); else n_pass++;
        n_checks++; if (add_a !== 32'h0) $display("FAIL midrst add_a: got %h expected 0", add_a); else n_pass++;
        repeat (2) tick();
        nreset = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL midrst release in_ready: got %b expected 1", in_ready); else n_pass++;
        push_pair(32'h41200000, 32'h41A00000);
        repeat (3) tick();
        n_checks++; if (add_a !== 32'h0) $display("FAIL midrst boot add_a: got %h expected 0", add_a); else n_pass++;
        boot_adder();
        run_pair("after_rst", 32'h41200000, 32'h41A00000, 32'h41F00000, 1'b1);
    endtask

    task automatic test_idle_rise;
        add_ready = 1'b1;
        tick();
        add_ready = 1'b0;
        tick();
        n_checks++; if (res_valid !== 1'b0) $display("FAIL idle rise res_valid: got %b expected 0", res_valid); else n_pass++;
        push_pair(32'hC0000000, 32'h40A00000);
        run_pair("idle_rise", 32'hC0000000, 32'h40A00000, 32'h40400000, 1'b1);
    endtask

`ifdef FPSEQ_ZERO_BYPASS_EN
    task automatic test_zero_bypass;
        logic [31:0] a_hold;
        logic [31:0] tab_a [3];
        logic [31:0] tab_b [3];
        logic [31:0] tab_r [3];
        tab_a[0] = 32'h00000000; tab_b[0] = 32'hC0400000; tab_r[0] = 32'hC0400000;
        tab_a[1] = 32'h80000000; tab_b[1] = 32'h80000000; tab_r[1] = 32'h80000000;
        tab_a[2] = 32'h80000000; tab_b[2] = 32'h00000000; tab_r[2] = 32'h00000000;
        for (int i = 0; i < 3; i++) begin
            a_hold = add_a;
            push_pair(tab_a[i], tab_b[i]);
            tick();
            n_checks++; if (res_valid !== 1'b1 || res_data !== tab_r[i])
                $display("FAIL bypass%0d: res_valid=%b res_data=%h expected 1/%h", i, res_valid, res_data, tab_r[i]); else n_pass++;
            n_checks++; if (add_a !== a_hold) $display("FAIL bypass%0d add_a: got %h expected %h", i, add_a, a_hold); else n_pass++;
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_boot_hold();
        test_basic();
        test_fifo_full();
        test_res_stall();
        test_reset_mid();
        test_idle_rise();
`ifdef FPSEQ_ZERO_BYPASS_EN
        test_zero_bypass();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
